// File: rtl/adder_pkg.sv
// Shared definitions for the registered ripple-carry adder and its parents.
package adder_pkg;

    localparam int unsigned ADDER_DATA_WD_DEFAULT = 4;

    // {carry-out, sum} result vector at the default operand width
    typedef logic [ADDER_DATA_WD_DEFAULT:0] adder_result_t;

endpackage : adder_pkg

// File: rtl/full_adder.sv
// Single-bit full-adder cell; one link of the ripple carry chain.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_sum,
    output logic o_carry
);

    logic half_sum;

    always_comb begin
        half_sum = i_a ^ i_b;
        o_sum    = half_sum ^ i_c;
        o_carry  = (i_a & i_b) | (i_c & half_sum);
    end

endmodule : full_adder

// File: rtl/ripple_carry_adder_reg.sv
// DATA_WD-bit ripple-carry adder with carry-in; {carry-out, sum} is captured
// in an output register with a registered valid flag.
module ripple_carry_adder_reg
    import adder_pkg::*;
#(
    parameter int unsigned DATA_WD = ADDER_DATA_WD_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic [DATA_WD-1:0] i_a,
    input  logic [DATA_WD-1:0] i_b,
    input  logic               i_c,
    output logic               o_valid,
    output logic [DATA_WD:0]   o_arith_out
);

    logic [DATA_WD:0]   carry;
    logic [DATA_WD-1:0] sum;

    assign carry[0] = i_c;

    for (genvar k = 0; k < DATA_WD; k++) begin : g_cell
        full_adder u_full_adder (
            .i_a     (i_a[k]),
            .i_b     (i_b[k]),
            .i_c     (carry[k]),
            .o_sum   (sum[k]),
            .o_carry (carry[k+1])
        );
    end

    // Carry-out is passed through raw; borrow/overflow meaning is the parent's call
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_arith_out <= '0;
            o_valid     <= 1'b0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_arith_out <= {carry[DATA_WD], sum};
            end
        end
    end

endmodule : ripple_carry_adder_reg

// File: tb/tb_ripple_carry_adder_reg.sv
// Self-checking bench: directed and randomized adds at DATA_WD = 4, 1 and 16
// against an arithmetic reference model of a + b + c with hold/reset rules.
module tb_ripple_carry_adder_reg;

    logic        clk;
    logic        rst;
    logic        valid;

    logic [3:0]  a4, b4;
    logic        c4;
    logic        ov4;
    logic [4:0]  out4;

    logic        a1, b1, c1;
    logic        ov1;
    logic [1:0]  out1;

    logic [15:0] a16, b16;
    logic        c16;
    logic        ov16;
    logic [16:0] out16;

    logic [4:0]  exp4;
    logic [1:0]  exp1;
    logic [16:0] exp16;
    logic        exp_valid;

    int unsigned tests;
    int unsigned failed;

    ripple_carry_adder_reg #(.DATA_WD(4)) u_dut4 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (valid),
        .i_a         (a4),
        .i_b         (b4),
        .i_c         (c4),
        .o_valid     (ov4),
        .o_arith_out (out4)
    );

    ripple_carry_adder_reg #(.DATA_WD(1)) u_dut1 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (valid),
        .i_a         (a1),
        .i_b         (b1),
        .i_c         (c1),
        .o_valid     (ov1),
        .o_arith_out (out1)
    );

    ripple_carry_adder_reg #(.DATA_WD(16)) u_dut16 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (valid),
        .i_a         (a16),
        .i_b         (b16),
        .i_c         (c16),
        .o_valid     (ov16),
        .o_arith_out (out16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance the model using the inputs present at the edge, clock, then compare all DUTs
    task automatic step_and_check();
        if (rst) begin
            exp4 = '0; exp1 = '0; exp16 = '0; exp_valid = 1'b0;
        end else begin
            exp_valid = valid;
            if (valid) begin
                exp4  = 5'(a4)   + 5'(b4)   + 5'(c4);
                exp1  = 2'(a1)   + 2'(b1)   + 2'(c1);
                exp16 = 17'(a16) + 17'(b16) + 17'(c16);
            end
        end
        @(posedge clk);
        #1;
        check("out_w4",    32'(out4),  32'(exp4));
        check("valid_w4",  32'(ov4),   32'(exp_valid));
        check("out_w1",    32'(out1),  32'(exp1));
        check("valid_w1",  32'(ov1),   32'(exp_valid));
        check("out_w16",   32'(out16), 32'(exp16));
        check("valid_w16", 32'(ov16),  32'(exp_valid));
    endtask

    task automatic randomize_wide();
        a1  = 1'($urandom);
        b1  = 1'($urandom);
        c1  = 1'($urandom);
        a16 = 16'($urandom);
        b16 = 16'($urandom);
        c16 = 1'($urandom);
    endtask

    task automatic set4(input logic [3:0] a, input logic [3:0] b, input logic c);
        a4 = a;
        b4 = b;
        c4 = c;
    endtask

    initial begin
        tests = 0;
        failed = 0;
        exp4 = '0; exp1 = '0; exp16 = '0; exp_valid = 1'b0;
        rst = 1'b1;
        valid = 1'b0;
        set4(4'd0, 4'd0, 1'b0);
        randomize_wide();

        // Reset for two cycles
        @(negedge clk);
        step_and_check();
        step_and_check();
        check("reset_out", 32'(out4), 32'd0);
        check("reset_valid", 32'(ov4), 32'd0);

        rst = 1'b0;
        valid = 1'b1;

        set4(4'd3, 4'd5, 1'b0); randomize_wide(); step_and_check();
        check("basic_add", 32'(out4), 32'b01000);

        set4(4'd15, 4'd1, 1'b0); randomize_wide(); step_and_check();
        check("carry_out", 32'(out4), 32'b10000);

        set4(4'd15, 4'd15, 1'b1); randomize_wide(); step_and_check();
        check("full_range", 32'(out4), 32'b11111);

        set4(4'd5, 4'd12, 1'b1); randomize_wide(); step_and_check();
        check("sub_no_borrow", 32'(out4), 32'b10010);

        set4(4'd3, 4'd10, 1'b1); randomize_wide(); step_and_check();
        check("sub_borrow", 32'(out4), 32'b01110);

        // Hold: load 8, then drop valid with new operands
        set4(4'd3, 4'd5, 1'b0); randomize_wide(); step_and_check();
        valid = 1'b0;
        set4(4'd1, 4'd1, 1'b0); randomize_wide(); step_and_check();
        check("hold_out", 32'(out4), 32'd8);
        check("hold_valid", 32'(ov4), 32'd0);
        randomize_wide(); step_and_check();

        // Reset wins over a valid operation in the same cycle
        rst = 1'b1;
        valid = 1'b1;
        set4(4'd7, 4'd7, 1'b0); randomize_wide(); step_and_check();
        check("rst_mid_out", 32'(out4), 32'd0);
        check("rst_mid_valid", 32'(ov4), 32'd0);
        rst = 1'b0;
        step_and_check();
        check("resume_out", 32'(out4), 32'd14);
        check("resume_valid", 32'(ov4), 32'd1);

        // Exhaustive at width 4, back-to-back; random operands on the other widths
        valid = 1'b1;
        for (int unsigned i = 0; i < 512; i++) begin
            set4(i[3:0], i[7:4], i[8]);
            randomize_wide();
            step_and_check();
        end

        // Random traffic with gaps in valid
        for (int unsigned i = 0; i < 300; i++) begin
            valid = 1'($urandom_range(0, 3) != 0);
            set4(4'($urandom), 4'($urandom), 1'($urandom));
            randomize_wide();
            step_and_check();
        end

        // Widest carries at width 16
        valid = 1'b1;
        a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1'b1;
        step_and_check();
        check("w16_max", 32'(out16), 32'h1FFFF);
        a16 = 16'hFFFF; b16 = 16'h0000; c16 = 1'b1;
        step_and_check();
        check("w16_ripple", 32'(out16), 32'h10000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_ripple_carry_adder_reg
